// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core-to-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DATA   = 2'b01,
    COMMIT = 2'b10,
    ERROR  = 2'b11
  } arb_state_e;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_DEFAULT = 8'd255;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-cycle counter for the arbiter: counts cycles spent with an unanswered
// memory request and flags the cycle in which the limit is reached.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  // Clear wins over increment so an ack or state change always restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = 8'd0;
    else if (inc) cnt_d = cnt_q + 8'd1;
  end

  // The edge that would make the count equal LIMIT is the expiring edge.
  assign expired = inc & (cnt_q == (LIMIT - 8'd1));

  // Wait counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for a multi-cycle core: fetch, optional data
// access, one-cycle commit. Optional timeout/ERROR state under the macro
// MEM_ARB_TIMEOUT_EN (default build: no counter, err tied low).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  arb_state_e  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_c, we_c;
  logic [31:0] addr_c, wdata_c;
  logic        timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wait_clr;
  assign wait_clr = mem_ack | (state_d != state_q);

  mem_arb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .inc     (mem_req & ~mem_ack),
    .clr     (wait_clr),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // Next-state, capture and bus decode; bus fields are zero whenever no request.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = 32'd0;
    wdata_c = 32'd0;
    case (state_q)
      FETCH: begin
        req_c  = 1'b1;
        addr_c = pc;
        if (mem_ack) begin
          instr_d = mem_rdata;
          state_d = DATA;
        end
      end
      DATA: begin
        if (mem_read | mem_write) begin
          req_c   = 1'b1;
          we_c    = mem_write;
          addr_c  = alu_result;
          wdata_c = write_data;
          if (mem_ack) begin
            if (mem_read) rdata_d = mem_rdata;
            state_d = COMMIT;
          end
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: state_d = FETCH;
`ifdef MEM_ARB_TIMEOUT_EN
      ERROR:  state_d = ERROR;
`else
      default: state_d = FETCH;
`endif
    endcase
    // timeout_hit implies no ack this cycle, so no capture is overridden.
    if (timeout_hit) state_d = ERROR;
  end

  // Core sees the bus only once out of reset; the core inputs are held by stall.
  assign mem_req   = rst & req_c;
  assign mem_we    = rst & we_c;
  assign mem_addr  = rst ? addr_c  : 32'd0;
  assign mem_wdata = rst ? wdata_c : 32'd0;

  assign stall     = (state_q != COMMIT);
  assign instr     = instr_q;
  assign read_data = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err       = (state_q == ERROR);
`else
  assign err       = 1'b0;
`endif

  // FSM state and captured instruction/load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      instr_q <= NOP_INSTR;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255; sets the wait-cycle limit before err. Width is 8 bits, range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 SHALL have port pc  input  32  fetch address from the core.
REQ-005 SHALL have port instr  output  32  registered instruction word to the core.
REQ-006 SHALL have port alu_result  input  32  data access address from the core.
REQ-007 SHALL have port write_data  input  32  store data from the core.
REQ-008 SHALL have port mem_write  input  1  core store request, decoded from instr.
REQ-009 SHALL have port mem_read  input  1  core load request, decoded from instr.
REQ-010 SHALL have port read_data  output  32  registered load data to the core.
REQ-011 SHALL have port stall  output  1  core freeze; core commits PC and register writes only when 0.
REQ-012 SHALL have ports mem_req, mem_we  output  1 each  unified memory request and write enable.
REQ-013 SHALL have ports mem_addr, mem_wdata  output  32 each  memory address and write data.
REQ-014 SHALL have port mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-015 SHALL have port mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-016 SHALL have port err  output  1  sticky memory timeout flag.

Function
REQ-017 SHALL implement an FSM with states FETCH, DATA, COMMIT and ERROR; ERROR exists only with the macro.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack, instr<=mem_rdata and the FSM goes to DATA.
REQ-019 DATA with mem_read|mem_write: mem_req=1, mem_we=mem_write, mem_addr=alu_result, mem_wdata=write_data.
REQ-020 DATA on mem_ack: if mem_read, read_data<=mem_rdata; the FSM goes to COMMIT.
REQ-021 DATA with neither mem_read nor mem_write: no request; the FSM goes to COMMIT on the next edge.
REQ-022 COMMIT: stall=0 for exactly one cycle, mem_req=0, then the FSM goes to FETCH.
REQ-023 stall SHALL be 1 in every state except COMMIT.
REQ-024 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ack=0.
REQ-025 SHALL accept a same-cycle ack (zero wait).
REQ-026 Minimum latency: 3 cycles per instruction, with or without a data access.
REQ-027 mem_ack while mem_req=0 SHALL be ignored with no state change.
REQ-028 mem_addr, mem_wdata and mem_we SHALL be 0 when mem_req=0.
REQ-029 instr and read_data SHALL hold their values outside capture edges.

Reset
REQ-030 rst=0 SHALL immediately force state=FETCH, instr=0x00000013 (NOP), read_data=0, err=0 and the wait counter to 0.
REQ-031 During reset, stall=1 and mem_req=0. mem_req rises in the first cycle after rst deasserts. Reset mid-access abandons the access with no capture.

Configuration
REQ-032 With macro MEM_ARB_TIMEOUT_EN defined, a wait counter increments each cycle with mem_req=1 and mem_ack=0, and clears on ack or state change. On reaching TIMEOUT_CYCLES the FSM enters ERROR: err=1, stall=1, mem_req=0, held until reset.
REQ-033 Without MEM_ARB_TIMEOUT_EN, the design has no counter and no ERROR state, err is tied 0, and the FSM waits indefinitely for mem_ack.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum (FETCH=2'b00, DATA=2'b01, COMMIT=2'b10, ERROR=2'b11), the NOP constant 32'h00000013 and the TIMEOUT_CYCLES default.
REQ-035 The timeout counter SHALL be the sub-module mem_arb_timer, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-036 ALU instruction, zero-wait ack, mem_read=mem_write=0 -> stall pattern 1,1,0 repeating; mem_req=1 only in the FETCH cycle.
REQ-037 Load at alu_result=0x100, mem_rdata=0xDEADBEEF, ack after 2 waits -> read_data=0xDEADBEEF during COMMIT; mem_addr stays 0x100 throughout the wait.
REQ-038 Store with write_data=0x12345678 -> a single mem_req cycle with mem_we=1 and mem_wdata=0x12345678; no read_data update.
REQ-039 Spurious mem_ack in COMMIT, plus rst=0 pulsed mid-DATA -> no capture, and instr=0x00000013 immediately.
REQ-040 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> err=1 after 4 wait cycles, mem_req=0, stall stuck at 1 until reset.
